// File: rtl/value_prediction_table.sv
// Direct-mapped last-value predictor with confidence counters and a registered prediction output.
// Define VPT_STATS_EN to enable the prediction/misprediction counters; otherwise they read as 0.
module value_prediction_table #(
  parameter int DATA_WIDTH  = 32,
  parameter int PC_WIDTH    = 32,
  parameter int INDEX_BITS  = 4,
  parameter int CONF_BITS   = 2,
  parameter int CONF_THRESH = 2
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Lookup_Valid,
  input  logic [PC_WIDTH-1:0]   i_Lookup_PC,
  input  logic                  i_Stall,
  input  logic                  i_Flush,
  input  logic                  i_Update_Valid,
  input  logic [PC_WIDTH-1:0]   i_Update_PC,
  input  logic [DATA_WIDTH-1:0] i_Update_Data,
  output logic                  o_Predict_Made,
  output logic [DATA_WIDTH-1:0] o_Predicted_Data,
  output logic                  o_Mispredict,
  output logic [31:0]           o_Num_Predictions,
  output logic [31:0]           o_Num_Mispredicts
);

  localparam int ENTRIES   = 1 << INDEX_BITS;
  localparam int TAG_WIDTH = PC_WIDTH - INDEX_BITS - 2;
  localparam logic [CONF_BITS-1:0] CONF_MAX = '1;

  logic [ENTRIES-1:0]    valid_q, valid_d;
  logic [TAG_WIDTH-1:0]  tag_q   [ENTRIES];
  logic [TAG_WIDTH-1:0]  tag_d   [ENTRIES];
  logic [DATA_WIDTH-1:0] value_q [ENTRIES];
  logic [DATA_WIDTH-1:0] value_d [ENTRIES];
  logic [CONF_BITS-1:0]  conf_q  [ENTRIES];
  logic [CONF_BITS-1:0]  conf_d  [ENTRIES];

  logic                  predict_made_q, predict_made_d;
  logic [DATA_WIDTH-1:0] predicted_data_q, predicted_data_d;
  logic                  mispredict_q, mispredict_d;

  logic [INDEX_BITS-1:0] lk_idx, upd_idx;
  logic [TAG_WIDTH-1:0]  lk_tag, upd_tag;
  logic                  lk_hit, lk_predict, upd_hit;
  logic                  unused_pc_bits;

  function automatic logic conf_ok(input logic [CONF_BITS-1:0] c);
    return 32'(c) >= 32'(CONF_THRESH);
  endfunction

  assign lk_idx  = i_Lookup_PC[INDEX_BITS+1:2];
  assign lk_tag  = i_Lookup_PC[PC_WIDTH-1:INDEX_BITS+2];
  assign upd_idx = i_Update_PC[INDEX_BITS+1:2];
  assign upd_tag = i_Update_PC[PC_WIDTH-1:INDEX_BITS+2];
  assign unused_pc_bits = ^{i_Lookup_PC[1:0], i_Update_PC[1:0]};

  // Lookup reads the registered table, so a same-cycle update is never bypassed.
  assign lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_predict = lk_hit && conf_ok(conf_q[lk_idx]);
  assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    predict_made_d   = predict_made_q;
    predicted_data_d = predicted_data_q;
    if (i_Flush) begin
      predict_made_d   = 1'b0;
      predicted_data_d = '0;
    end else if (!i_Stall) begin
      predict_made_d   = i_Lookup_Valid && lk_predict;
      predicted_data_d = (i_Lookup_Valid && lk_predict) ? value_q[lk_idx] : '0;
    end
  end

  always_comb begin
    valid_d      = valid_q;
    tag_d        = tag_q;
    value_d      = value_q;
    conf_d       = conf_q;
    mispredict_d = 1'b0;
    if (i_Update_Valid) begin
      if (!upd_hit) begin
        valid_d[upd_idx] = 1'b1;
        tag_d[upd_idx]   = upd_tag;
        value_d[upd_idx] = i_Update_Data;
        conf_d[upd_idx]  = '0;
      end else if (value_q[upd_idx] == i_Update_Data) begin
        if (conf_q[upd_idx] != CONF_MAX) begin
          conf_d[upd_idx] = conf_q[upd_idx] + 1'b1;
        end
      end else begin
        value_d[upd_idx] = i_Update_Data;
        conf_d[upd_idx]  = '0;
        mispredict_d     = conf_ok(conf_q[upd_idx]);
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      valid_q          <= '0;
      predict_made_q   <= 1'b0;
      predicted_data_q <= '0;
      mispredict_q     <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]   <= '0;
        value_q[i] <= '0;
        conf_q[i]  <= '0;
      end
    end else begin
      valid_q          <= valid_d;
      tag_q            <= tag_d;
      value_q          <= value_d;
      conf_q           <= conf_d;
      predict_made_q   <= predict_made_d;
      predicted_data_q <= predicted_data_d;
      mispredict_q     <= mispredict_d;
    end
  end

  assign o_Predict_Made   = predict_made_q;
  assign o_Predicted_Data = predicted_data_q;
  assign o_Mispredict     = mispredict_q;

`ifdef VPT_STATS_EN
  logic [31:0] num_pred_q, num_pred_d;
  logic [31:0] num_mis_q, num_mis_d;
  logic        pred_fire;

  // Only freshly registered predictions count; a stall-held prediction is not re-counted.
  assign pred_fire = !i_Flush && !i_Stall && i_Lookup_Valid && lk_predict;

  always_comb begin
    num_pred_d = num_pred_q + (pred_fire ? 32'd1 : 32'd0);
    num_mis_d  = num_mis_q + (mispredict_d ? 32'd1 : 32'd0);
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      num_pred_q <= '0;
      num_mis_q  <= '0;
    end else begin
      num_pred_q <= num_pred_d;
      num_mis_q  <= num_mis_d;
    end
  end

  assign o_Num_Predictions = num_pred_q;
  assign o_Num_Mispredicts = num_mis_q;
`else
  assign o_Num_Predictions = '0;
  assign o_Num_Mispredicts = '0;
`endif

endmodule

// File: tb/tb_value_prediction_table.sv
// Scoreboard bench for value_prediction_table: a per-cycle reference model queues the
// expected outputs and a monitor compares them one edge later.
module tb_value_prediction_table;

  localparam int ENTRIES = 16;
`ifdef VPT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        i_Clk = 1'b0;
  logic        i_Reset = 1'b0;
  logic        i_Lookup_Valid = 1'b0;
  logic [31:0] i_Lookup_PC = '0;
  logic        i_Stall = 1'b0;
  logic        i_Flush = 1'b0;
  logic        i_Update_Valid = 1'b0;
  logic [31:0] i_Update_PC = '0;
  logic [31:0] i_Update_Data = '0;
  logic        o_Predict_Made;
  logic [31:0] o_Predicted_Data;
  logic        o_Mispredict;
  logic [31:0] o_Num_Predictions;
  logic [31:0] o_Num_Mispredicts;

  value_prediction_table dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset),
    .i_Lookup_Valid(i_Lookup_Valid), .i_Lookup_PC(i_Lookup_PC),
    .i_Stall(i_Stall), .i_Flush(i_Flush),
    .i_Update_Valid(i_Update_Valid), .i_Update_PC(i_Update_PC), .i_Update_Data(i_Update_Data),
    .o_Predict_Made(o_Predict_Made), .o_Predicted_Data(o_Predicted_Data),
    .o_Mispredict(o_Mispredict),
    .o_Num_Predictions(o_Num_Predictions), .o_Num_Mispredicts(o_Num_Mispredicts)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    bit          valid;
    int unsigned tag;
    logic [31:0] value;
    int          conf;
  } ent_t;

  typedef struct {
    logic        made;
    logic [31:0] data;
    logic        mis;
    logic [31:0] npred;
    logic [31:0] nmis;
  } exp_t;

  ent_t        mdl[ENTRIES];
  exp_t        exp_q[$];
  logic        m_made;
  logic [31:0] m_data;
  logic [31:0] m_npred;
  logic [31:0] m_nmis;
  int          checks = 0;
  int          passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s actual=%h expected=%h", name, act, want);
  endtask

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) mdl[i] = '{valid: 1'b0, tag: 0, value: '0, conf: 0};
    m_made  = 1'b0;
    m_data  = '0;
    m_npred = '0;
    m_nmis  = '0;
  endtask

  // One cycle: drive inputs at the falling edge, advance the model, queue the expectation.
  task automatic step(input bit rst, input bit lv, input logic [31:0] lpc,
                      input bit st, input bit fl,
                      input bit uv, input logic [31:0] upc, input logic [31:0] ud);
    exp_t e;
    int   li, ui;
    bit   mis;
    @(negedge i_Clk);
    i_Reset        = rst;
    i_Lookup_Valid = lv;
    i_Lookup_PC    = lpc;
    i_Stall        = st;
    i_Flush        = fl;
    i_Update_Valid = uv;
    i_Update_PC    = upc;
    i_Update_Data  = ud;
    mis = 1'b0;
    if (rst) begin
      model_clear();
    end else begin
      li = int'((lpc / 4) % ENTRIES);
      ui = int'((upc / 4) % ENTRIES);
      if (fl) begin
        m_made = 1'b0;
        m_data = '0;
      end else if (!st) begin
        if (lv && mdl[li].valid && mdl[li].tag == lpc / 64 && mdl[li].conf >= 2) begin
          m_made = 1'b1;
          m_data = mdl[li].value;
          if (STATS) m_npred++;
        end else begin
          m_made = 1'b0;
          m_data = '0;
        end
      end
      if (uv) begin
        if (!(mdl[ui].valid && mdl[ui].tag == upc / 64)) begin
          mdl[ui] = '{valid: 1'b1, tag: upc / 64, value: ud, conf: 0};
        end else if (mdl[ui].value == ud) begin
          if (mdl[ui].conf < 3) mdl[ui].conf++;
        end else begin
          mis = (mdl[ui].conf >= 2);
          mdl[ui].value = ud;
          mdl[ui].conf  = 0;
        end
      end
      if (mis && STATS) m_nmis++;
    end
    e = '{made: m_made, data: m_data, mis: mis, npred: m_npred, nmis: m_nmis};
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(posedge i_Clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("predict_made", 32'(o_Predict_Made), 32'(e.made));
      check("predicted_data", o_Predicted_Data, e.data);
      check("mispredict", 32'(o_Mispredict), 32'(e.mis));
      check("num_predictions", o_Num_Predictions, e.npred);
      check("num_mispredicts", o_Num_Mispredicts, e.nmis);
    end
  end

  initial begin
    logic [31:0] lpc, upc;
    model_clear();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h100, 0, 0, 1, 32'h100, 32'h55);
    idle();
    // Cold lookup
    step(0, 1, 32'h100, 0, 0, 0, 0, 0);
    idle();
    // Train to confidence 2 and predict
    repeat (3) step(0, 0, 0, 0, 0, 1, 32'h100, 32'h55);
    step(0, 1, 32'h100, 0, 0, 0, 0, 0);
    idle();
    // Confident wrong value
    step(0, 0, 0, 0, 0, 1, 32'h100, 32'h66);
    step(0, 1, 32'h100, 0, 0, 0, 0, 0);
    idle();
    // Alias replacement at index 0
    repeat (2) step(0, 0, 0, 0, 0, 1, 32'h100, 32'h66);
    step(0, 0, 0, 0, 0, 1, 32'h140, 32'h9);
    step(0, 1, 32'h100, 0, 0, 0, 0, 0);
    idle();
    // Stall hold, then flush beats stall
    repeat (3) step(0, 0, 0, 0, 0, 1, 32'h100, 32'h55);
    step(0, 1, 32'h100, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 32'h140, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 32'h100, 1, 1, 0, 0, 0);
    idle();
    // Same-cycle update and lookup sees old confidence
    step(0, 0, 0, 0, 0, 1, 32'h100, 32'h77);
    step(0, 0, 0, 0, 0, 1, 32'h100, 32'h77);
    step(0, 1, 32'h100, 0, 0, 1, 32'h100, 32'h77);
    step(0, 1, 32'h100, 0, 0, 0, 0, 0);
    idle();
    // Reset mid-operation discards the update
    step(1, 0, 0, 0, 0, 1, 32'h100, 32'h77);
    step(0, 1, 32'h100, 0, 0, 0, 0, 0);
    idle();
    // Randomized traffic over a few aliasing PCs and a small value set
    for (int n = 0; n < 3000; n++) begin
      lpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      upc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      step(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1, lpc,
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
           $urandom_range(0, 3) != 0, upc, 32'($urandom_range(0, 2)));
    end
    idle();
    for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge i_Clk);
    #2;
    if (exp_q.size() > 0) check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
